// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit with read-modify-write for sub-word stores
//
// Ports:
//   clk, reset           clock and asynchronous active-low reset
//   req_valid/req_ready  request handshake (accept when both high on a rising edge)
//   req_write, funct3    store/load select and RISC-V width code
//   addr, store_data     byte address and store operand
//   done, fault          one-cycle completion pulse and reject flag valid with it
//   load_data            formatted load result, held until the next completed load
//   MemRead, MemWrite    data memory strobes (never both high)
//   Mem_Addr, wr_data    word index and write word to data memory
//   rd_data              combinational read word from data memory

module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        req_ready,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Mem_Addr,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        write_q, write_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] load_data_q, load_data_d;
    logic        fault_q, fault_d;

    logic        req_fault;
    logic        illegal;
    logic        misaligned;
    logic [31:0] load_fmt;
    logic [31:0] merged;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Request checks operate on the live inputs so the decision is latched at acceptance.
    always_comb begin
        if (req_write) begin
            illegal = funct3[2] | (funct3 == 3'b011);
        end else begin
            illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
        end
        misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                     ((funct3 == 3'b010) & (addr[1:0] != 2'b00));
        // Memory is 64 words, so any address bit above 7 is out of range.
        req_fault  = illegal | misaligned | (|addr[31:8]);
    end

    // Little-endian lane selection from the latched address.
    always_comb begin
        sel_byte = rd_data[{addr_q[1:0], 3'b000} +: 8];
        sel_half = addr_q[1] ? rd_data[31:16] : rd_data[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_fmt = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_fmt = {24'h0, sel_byte};
            3'b101:  load_fmt = {16'h0, sel_half};
            default: load_fmt = rd_data;
        endcase
    end

    // Sub-word store: replace only the addressed lanes of the word captured in RMW_RD.
    always_comb begin
        merged = merge_q;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = sdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = sdata_q[15:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        write_d     = write_q;
        sdata_d     = sdata_q;
        merge_d     = merge_q;
        load_data_d = load_data_q;
        fault_d     = fault_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = addr;
                    funct3_d = funct3;
                    write_d  = req_write;
                    sdata_d  = store_data;
                    fault_d  = req_fault;
                    if (req_fault) begin
                        state_d = S_RESP;
                    end else if (!req_write) begin
                        state_d = S_LOAD;
                    end else if (funct3 == 3'b010) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                load_data_d = load_fmt;
                state_d     = S_RESP;
            end
            S_STORE: begin
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                merge_d = rd_data;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'h0;
            funct3_q    <= 3'b000;
            write_q     <= 1'b0;
            sdata_q     <= 32'h0;
            merge_q     <= 32'h0;
            load_data_q <= 32'h0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            write_q     <= write_d;
            sdata_q     <= sdata_d;
            merge_q     <= merge_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
        end
    end

    // Strobes and handshake are pure state decodes, so reset removes them immediately.
    assign req_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_RESP);
    assign fault     = (state_q == S_RESP) & fault_q;
    assign MemRead   = (state_q == S_LOAD) | (state_q == S_RMW_RD);
    assign MemWrite  = (state_q == S_STORE) | (state_q == S_RMW_WR);
    assign Mem_Addr  = {2'b00, addr_q[31:2]};
    assign wr_data   = (state_q == S_STORE) ? sdata_q : merged;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - table-driven self-checking bench for load_store_unit

module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        req_ready;
    logic        done;
    logic        fault;
    logic [31:0] load_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Mem_Addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .req_ready  (req_ready),
        .done       (done),
        .fault      (fault),
        .load_data  (load_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Mem_Addr   (Mem_Addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: 64 words, combinational read, write on rising edge.
    logic [31:0] mem [64];
    logic        init_we;
    logic [5:0]  init_idx;
    logic [31:0] init_val;

    assign rd_data = MemRead ? mem[Mem_Addr[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (init_we) mem[init_idx] <= init_val;
        else if (MemWrite) mem[Mem_Addr[5:0]] <= wr_data;
    end

    int accepts;
    initial accepts = 0;
    always @(posedge clk) begin
        if (reset && req_valid && req_ready) accepts <= accepts + 1;
    end

    int passed;
    int total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        init_we  = 1'b1;
        init_idx = idx[5:0];
        init_val = val;
        @(posedge clk);
        #1 init_we = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        int          lat;
        logic        flt;
        logic [31:0] ld;
        int          nrd;
        int          nwr;
        int          widx;
        logic [31:0] wexp;
    } vec_t;

    task automatic do_op(input string tag, input vec_t v);
        int lat, nrd, nwr, bad;
        logic got_fault;
        logic [31:0] got_ld;
        lat = 0; nrd = 0; nwr = 0; bad = 0;
        got_fault = 1'b0;
        got_ld = 32'h0;
        @(negedge clk);
        chk({tag, " ready"}, {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_write  = v.wr;
        funct3     = v.f3;
        addr       = v.a;
        store_data = v.sd;
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance: the operation must use latched values.
        req_valid  = 1'b0;
        req_write  = ~v.wr;
        funct3     = 3'b111;
        addr       = 32'hFFFF_FFFC;
        store_data = 32'h0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (MemRead) nrd++;
            if (MemWrite) nwr++;
            if (MemRead && MemWrite) bad++;
            if ((MemRead || MemWrite) && Mem_Addr != {2'b00, v.a[31:2]}) bad++;
            if (done) begin
                lat = k;
                got_fault = fault;
                got_ld = load_data;
            end
        end
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " fault"}, {31'h0, got_fault}, {31'h0, v.flt});
        chk({tag, " load_data"}, got_ld, v.ld);
        chk({tag, " reads"}, nrd, v.nrd);
        chk({tag, " writes"}, nwr, v.nwr);
        chk({tag, " strobe_addr"}, bad, 0);
        chk({tag, " mem_word"}, mem[v.widx], v.wexp);
    endtask

    vec_t vecs[17];

    initial begin
        int found, dn, issued, a0;
        vec_t v;
        passed = 0;
        total = 0;
        init_we = 1'b0;
        init_idx = 6'd0;
        init_val = 32'h0;
        req_valid = 1'b0;
        req_write = 1'b0;
        funct3 = 3'b000;
        addr = 32'h0;
        store_data = 32'h0;

        //             wr    f3      addr    sdata         lat flt ld              rd wr idx word
        vecs[0]  = '{1'b0, 3'b000, 32'h08, 32'h0,         2, 1'b0, 32'hFFFF_FFA1, 1, 0, 2, 32'h8765_43A1};
        vecs[1]  = '{1'b0, 3'b101, 32'h0A, 32'h0,         2, 1'b0, 32'h0000_8765, 1, 0, 2, 32'h8765_43A1};
        vecs[2]  = '{1'b0, 3'b001, 32'h0A, 32'h0,         2, 1'b0, 32'hFFFF_8765, 1, 0, 2, 32'h8765_43A1};
        vecs[3]  = '{1'b0, 3'b100, 32'h08, 32'h0,         2, 1'b0, 32'h0000_00A1, 1, 0, 2, 32'h8765_43A1};
        vecs[4]  = '{1'b0, 3'b010, 32'h08, 32'h0,         2, 1'b0, 32'h8765_43A1, 1, 0, 2, 32'h8765_43A1};
        vecs[5]  = '{1'b0, 3'b000, 32'h0B, 32'h0,         2, 1'b0, 32'hFFFF_FF87, 1, 0, 2, 32'h8765_43A1};
        vecs[6]  = '{1'b1, 3'b000, 32'h0D, 32'h0000_00AB, 3, 1'b0, 32'hFFFF_FF87, 1, 1, 3, 32'h1122_AB44};
        vecs[7]  = '{1'b1, 3'b010, 32'h0C, 32'hDEAD_BEEF, 2, 1'b0, 32'hFFFF_FF87, 0, 1, 3, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 3'b001, 32'h0E, 32'h0000_1234, 3, 1'b0, 32'hFFFF_FF87, 1, 1, 3, 32'h1234_BEEF};
        vecs[9]  = '{1'b0, 3'b010, 32'h0C, 32'h0,         2, 1'b0, 32'h1234_BEEF, 1, 0, 3, 32'h1234_BEEF};
        vecs[10] = '{1'b0, 3'b010, 32'h06, 32'h0,         1, 1'b1, 32'h1234_BEEF, 0, 0, 3, 32'h1234_BEEF};
        vecs[11] = '{1'b1, 3'b001, 32'h03, 32'h0000_9999, 1, 1'b1, 32'h1234_BEEF, 0, 0, 0, 32'h0};
        vecs[12] = '{1'b0, 3'b000, 32'h100, 32'h0,        1, 1'b1, 32'h1234_BEEF, 0, 0, 0, 32'h0};
        vecs[13] = '{1'b0, 3'b011, 32'h00, 32'h0,         1, 1'b1, 32'h1234_BEEF, 0, 0, 0, 32'h0};
        vecs[14] = '{1'b1, 3'b100, 32'h0C, 32'h0000_00FF, 1, 1'b1, 32'h1234_BEEF, 0, 0, 3, 32'h1234_BEEF};
        vecs[15] = '{1'b1, 3'b000, 32'h0F, 32'h0000_01FF, 3, 1'b0, 32'h1234_BEEF, 1, 1, 3, 32'hFF34_BEEF};
        vecs[16] = '{1'b0, 3'b001, 32'h0C, 32'h0,         2, 1'b0, 32'hFFFF_BEEF, 1, 0, 3, 32'hFF34_BEEF};

        reset = 1'b0;
        poke(0, 32'h0);
        poke(2, 32'h8765_43A1);
        poke(3, 32'h1122_3344);
        poke(4, 32'hCAFE_F00D);
        poke(5, 32'h0);

        @(negedge clk);
        chk("rst ready", {31'h0, req_ready}, 32'h1);
        chk("rst done", {31'h0, done}, 32'h0);
        chk("rst fault", {31'h0, fault}, 32'h0);
        chk("rst strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        chk("rst load_data", load_data, 32'h0);
        chk("rst mem_addr", Mem_Addr, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) do_op($sformatf("vec%0d", i), vecs[i]);

        // Reset during RMW_WR of SH 0x10: write aborted, no done.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b001;
        addr = 32'h10; store_data = 32'h0000_5555;
        @(posedge clk);
        #1 req_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 6 && found == 0; k++) begin
            @(negedge clk);
            if (MemWrite) found = 1;
        end
        chk("rmw reached write", found, 1);
        reset = 1'b0;
        #1;
        chk("abort memwrite", {31'h0, MemWrite}, 32'h0);
        chk("abort memread", {31'h0, MemRead}, 32'h0);
        chk("abort ready", {31'h0, req_ready}, 32'h1);
        chk("abort load_data", load_data, 32'h0);
        dn = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort no done", dn, 0);
        chk("abort word4", mem[4], 32'hCAFE_F00D);

        v = '{1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'hCAFE_F00D, 1, 0, 4, 32'hCAFE_F00D};
        do_op("post_reset lw", v);

        // Streaming: req_valid held high, alternating SW/LW to word 5.
        a0 = accepts;
        dn = 0;
        issued = 0;
        for (int c = 0; c < 80 && dn < 6; c++) begin
            @(negedge clk);
            if (done) begin
                if (dn % 2 == 1) chk($sformatf("stream ld%0d", dn), load_data, 32'h1000 + dn - 1);
                dn++;
            end
            if (req_ready && issued < 6) begin
                req_valid  = 1'b1;
                req_write  = (issued % 2 == 0);
                funct3     = 3'b010;
                addr       = 32'h14;
                store_data = 32'h1000 + issued;
                issued++;
            end
        end
        req_valid = 1'b0;
        chk("stream dones", dn, 6);
        @(negedge clk);
        chk("stream accepts", accepts - a0, 6);
        chk("stream word5", mem[5], 32'h0000_1004);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
